// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one registered single-port memory.
// Data has priority; a saturating counter bounds fetch starvation.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        IF_req_valid,
    input  logic [31:0] IF_req_address,
    output logic        IF_req_ready,
    output logic        IF_rsp_valid,
    output logic [31:0] IF_rsp_data,
    input  logic        D_req_valid,
    input  logic        D_req_write,
    input  logic [1:0]  D_req_length,
    input  logic        D_req_signed,
    input  logic [31:0] D_req_address,
    input  logic [31:0] D_req_wdata,
    output logic        D_req_ready,
    output logic        D_rsp_valid,
    output logic [31:0] D_rsp_data,
    output logic        D_rsp_error,
    output logic        MEM_en,
    output logic        MEM_write,
    output logic [1:0]  MEM_length,
    output logic        MEM_signed,
    output logic [31:0] MEM_address,
    output logic [31:0] MEM_wdata,
    input  logic [31:0] MEM_read_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        grant_d, grant_f, misaligned;
    logic        is_data_q, err_q;
    logic        mem_en_q, mem_write_q, mem_signed_q;
    logic [1:0]  mem_length_q;
    logic [31:0] mem_address_q, mem_wdata_q;
    logic        if_rsp_valid_q, d_rsp_valid_q, d_rsp_error_q;
    logic [31:0] if_rsp_data_q, d_rsp_data_q;

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_d || grant_f) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants only from IDLE; fetch overrides data once starved
    always_comb begin
        grant_d = 1'b0;
        grant_f = 1'b0;
        if (state_q == IDLE && SYS_reset) begin
            if (D_req_valid && !(IF_req_valid && starve_q == LIMIT))
                grant_d = 1'b1;
            else if (IF_req_valid)
                grant_f = 1'b1;
        end
    end

    assign IF_req_ready = grant_f;
    assign D_req_ready  = grant_d;

    always_comb begin
        starve_d = starve_q;
        if (grant_f)
            starve_d = 4'd0;
        else if (grant_d)
            starve_d = !IF_req_valid ? 4'd0 :
                       (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
    end

    always_comb begin
        misaligned = 1'b0;
        unique case (D_req_length)
            2'b01:   misaligned = 1'b0;
            2'b10:   misaligned = D_req_address[0];
            2'b11:   misaligned = |D_req_address[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            is_data_q      <= 1'b0;
            err_q          <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_length_q   <= 2'b00;
            mem_signed_q   <= 1'b0;
            mem_address_q  <= 32'd0;
            mem_wdata_q    <= 32'd0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= 32'd0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_data_q   <= 32'd0;
            d_rsp_error_q  <= 1'b0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_error_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        is_data_q     <= 1'b1;
                        err_q         <= misaligned;
                        mem_en_q      <= !misaligned;
                        mem_write_q   <= D_req_write;
                        mem_length_q  <= D_req_length;
                        mem_signed_q  <= D_req_signed;
                        mem_address_q <= D_req_address;
                        mem_wdata_q   <= D_req_wdata;
                    end else if (grant_f) begin
                        is_data_q     <= 1'b0;
                        err_q         <= 1'b0;
                        mem_en_q      <= 1'b1;
                        mem_write_q   <= 1'b0;
                        mem_length_q  <= 2'b11;
                        mem_signed_q  <= 1'b0;
                        mem_address_q <= IF_req_address & 32'hFFFF_FFFC;
                        mem_wdata_q   <= 32'd0;
                    end
                end
                ISSUE: mem_en_q <= 1'b0;
                CAPTURE: begin
                    if (is_data_q) begin
                        d_rsp_valid_q <= 1'b1;
                        d_rsp_error_q <= err_q;
                        d_rsp_data_q  <= (err_q || mem_write_q) ?
                                         32'd0 : MEM_read_data;
                    end else begin
                        if_rsp_valid_q <= 1'b1;
                        if_rsp_data_q  <= MEM_read_data;
                    end
                end
                default: mem_en_q <= 1'b0;
            endcase
        end
    end

    assign MEM_en       = mem_en_q;
    assign MEM_write    = mem_write_q;
    assign MEM_length   = mem_length_q;
    assign MEM_signed   = mem_signed_q;
    assign MEM_address  = mem_address_q;
    assign MEM_wdata    = mem_wdata_q;
    assign IF_rsp_valid = if_rsp_valid_q;
    assign IF_rsp_data  = if_rsp_data_q;
    assign D_rsp_valid  = d_rsp_valid_q;
    assign D_rsp_data   = d_rsp_data_q;
    assign D_rsp_error  = d_rsp_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a per-cycle
// transaction schedule model.
module tb_mem_port_arbiter;

    localparam int LIM  = 4;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        SYS_reset = 1'b0;
    logic        IF_req_valid = 1'b0;
    logic [31:0] IF_req_address = '0;
    logic        IF_req_ready;
    logic        IF_rsp_valid;
    logic [31:0] IF_rsp_data;
    logic        D_req_valid = 1'b0;
    logic        D_req_write = 1'b0;
    logic [1:0]  D_req_length = 2'b00;
    logic        D_req_signed = 1'b0;
    logic [31:0] D_req_address = '0;
    logic [31:0] D_req_wdata = '0;
    logic        D_req_ready;
    logic        D_rsp_valid;
    logic [31:0] D_rsp_data;
    logic        D_rsp_error;
    logic        MEM_en, MEM_write, MEM_signed;
    logic [1:0]  MEM_length;
    logic [31:0] MEM_address, MEM_wdata;
    logic [31:0] MEM_read_data = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .SYS_clk(clk), .SYS_reset(SYS_reset),
        .IF_req_valid(IF_req_valid), .IF_req_address(IF_req_address),
        .IF_req_ready(IF_req_ready), .IF_rsp_valid(IF_rsp_valid),
        .IF_rsp_data(IF_rsp_data),
        .D_req_valid(D_req_valid), .D_req_write(D_req_write),
        .D_req_length(D_req_length), .D_req_signed(D_req_signed),
        .D_req_address(D_req_address), .D_req_wdata(D_req_wdata),
        .D_req_ready(D_req_ready), .D_rsp_valid(D_rsp_valid),
        .D_rsp_data(D_rsp_data), .D_rsp_error(D_rsp_error),
        .MEM_en(MEM_en), .MEM_write(MEM_write), .MEM_length(MEM_length),
        .MEM_signed(MEM_signed), .MEM_address(MEM_address),
        .MEM_wdata(MEM_wdata), .MEM_read_data(MEM_read_data)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0613;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    always @(posedge clk)
        if (MEM_en === 1'b1) MEM_read_data <= memf(MEM_address);

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    bit          x_men[MAXC], x_mwr[MAXC], x_msg[MAXC];
    logic [1:0]  x_mlen[MAXC];
    logic [31:0] x_maddr[MAXC], x_mwd[MAXC];
    bit          x_ifv[MAXC], x_dv[MAXC], x_de[MAXC], x_zero[MAXC];
    logic [31:0] x_ifd[MAXC], x_dd[MAXC];

    int free_at = 0;
    int starve = 0;
    int pf = 0, pd = 0;
    bit rst_cmd = 1'b0;
    bit rec = 1'b0;
    int gq[$];

    bit          f_pend = 0, d_pend = 0;
    logic [31:0] f_addr = '0, d_addr = '0, d_wd = '0;
    logic [1:0]  d_len = 2'b00;
    logic        d_wr = 0, d_sg = 0;

    task automatic step();
        bit g_d, g_f, mis;
        @(negedge clk);
        chk("mem_en", MEM_en, x_men[cyc]);
        if (x_men[cyc]) begin
            chk("mem_addr", MEM_address, x_maddr[cyc]);
            chk("mem_write", MEM_write, x_mwr[cyc]);
            chk("mem_len", MEM_length, x_mlen[cyc]);
            chk("mem_signed", MEM_signed, x_msg[cyc]);
            if (x_mwr[cyc]) chk("mem_wdata", MEM_wdata, x_mwd[cyc]);
        end
        chk("if_rsp_v", IF_rsp_valid, x_ifv[cyc]);
        if (x_ifv[cyc]) chk("if_rsp_data", IF_rsp_data, x_ifd[cyc]);
        chk("d_rsp_v", D_rsp_valid, x_dv[cyc]);
        chk("d_rsp_err", D_rsp_error, x_dv[cyc] ? x_de[cyc] : 1'b0);
        if (x_dv[cyc]) chk("d_rsp_data", D_rsp_data, x_dd[cyc]);
        if (x_zero[cyc]) begin
            chk("rst_if_data", IF_rsp_data, 32'd0);
            chk("rst_d_data", D_rsp_data, 32'd0);
        end
        if (!f_pend && $urandom_range(0, 99) < pf) begin
            f_pend = 1;
            f_addr = $urandom_range(0, 1023) * 4;
            if ($urandom_range(0, 3) == 0) f_addr += $urandom_range(1, 3);
        end
        if (!d_pend && $urandom_range(0, 99) < pd) begin
            d_pend = 1;
            d_addr = $urandom_range(0, 4095);
            if ($urandom_range(0, 3) != 0) d_addr &= ~32'h3;
            d_len = ($urandom_range(0, 9) == 0) ? 2'b00 :
                    2'($urandom_range(1, 3));
            d_wr = 1'($urandom_range(0, 1));
            d_sg = 1'($urandom_range(0, 1));
            d_wd = $urandom;
        end
        SYS_reset      = rst_cmd;
        IF_req_valid   = f_pend;
        IF_req_address = f_addr;
        D_req_valid    = d_pend;
        D_req_address  = d_addr;
        D_req_length   = d_len;
        D_req_write    = d_wr;
        D_req_signed   = d_sg;
        D_req_wdata    = d_wd;
        #1;
        g_d = rst_cmd && cyc >= free_at && d_pend &&
              !(f_pend && starve == LIM);
        g_f = rst_cmd && cyc >= free_at && f_pend && !g_d;
        chk("if_ready", IF_req_ready, g_f);
        chk("d_ready", D_req_ready, g_d);
        if (rec && (IF_req_ready || D_req_ready))
            gq.push_back(D_req_ready ? 1 : 2);
        if (!rst_cmd) begin
            for (int k = 1; k <= 3; k++) begin
                x_men[cyc+k] = 0;
                x_ifv[cyc+k] = 0;
                x_dv[cyc+k]  = 0;
            end
            x_zero[cyc+1] = 1;
            starve = 0;
            free_at = cyc + 1;
        end else if (g_d) begin
            mis = (d_len == 2'b00) || (d_len == 2'b10 && d_addr[0]) ||
                  (d_len == 2'b11 && d_addr[1:0] != 2'b00);
            if (!mis) begin
                x_men[cyc+1]   = 1;
                x_maddr[cyc+1] = d_addr;
                x_mwr[cyc+1]   = d_wr;
                x_mlen[cyc+1]  = d_len;
                x_msg[cyc+1]   = d_sg;
                x_mwd[cyc+1]   = d_wd;
            end
            x_dv[cyc+3] = 1;
            x_de[cyc+3] = mis;
            x_dd[cyc+3] = (mis || d_wr) ? 32'd0 : memf(d_addr);
            starve = f_pend ? ((starve + 1 > LIM) ? LIM : starve + 1) : 0;
            free_at = cyc + 3;
            d_pend = 0;
        end else if (g_f) begin
            x_men[cyc+1]   = 1;
            x_maddr[cyc+1] = f_addr & ~32'h3;
            x_mwr[cyc+1]   = 0;
            x_mlen[cyc+1]  = 2'b11;
            x_msg[cyc+1]   = 0;
            x_ifv[cyc+3]   = 1;
            x_ifd[cyc+3]   = memf(f_addr & ~32'h3);
            starve = 0;
            free_at = cyc + 3;
            f_pend = 0;
        end
        cyc++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        rst_cmd = 0;
        repeat (3) step();
        rst_cmd = 1;
        step();

        f_addr = 32'h10; f_pend = 1;
        repeat (5) step();

        d_addr = 32'h103; d_wd = 32'hAB; d_len = 2'b01;
        d_wr = 1; d_sg = 0; d_pend = 1;
        repeat (5) step();

        d_addr = 32'h102; d_len = 2'b11; d_wr = 0; d_pend = 1;
        repeat (5) step();

        rec = 1; pf = 100; pd = 100;
        repeat (40) step();
        rec = 0; pf = 0; pd = 0;
        repeat (12) step();
        for (int k = 0; k < 10; k++)
            chk("grant_order", (gq.size() > k) ? gq[k] : 0,
                (k % 5 == 4) ? 2 : 1);

        d_addr = 32'h200; d_len = 2'b11; d_wr = 0; d_pend = 1;
        step();
        rst_cmd = 0;
        step();
        rst_cmd = 1;
        repeat (2) step();
        f_addr = 32'h40; f_pend = 1;
        d_addr = 32'h300; d_len = 2'b11; d_wr = 0; d_pend = 1;
        repeat (8) step();

        d_addr = 32'h400; d_len = 2'b10; d_wr = 0; d_sg = 1; d_pend = 1;
        repeat (2) step();
        f_addr = 32'h80; f_pend = 1;
        repeat (8) step();

        for (int b = 0; b < 20; b++) begin
            pf = $urandom_range(0, 100);
            pd = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++) begin
                rst_cmd = ($urandom_range(0, 299) != 0);
                step();
            end
        end
        rst_cmd = 1; pf = 0; pd = 0;
        repeat (15) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning: maximum consecutive data grants while fetch waits; legal range 1..15.
REQ-002 SYS_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SYS_reset  input  1  synchronous, active-low reset.
REQ-004 IF_req_valid  input  1  fetch request pending.
REQ-005 IF_req_address  input  32  fetch byte address, word access.
REQ-006 IF_req_ready  output  1  fetch request accepted this cycle.
REQ-007 IF_rsp_valid / IF_rsp_data  output  1 / 32  one-cycle fetch response pulse and instruction word.
REQ-008 D_req_valid  input  1  data request pending.
REQ-009 D_req_write / D_req_length / D_req_signed  input  1 / 2 / 1  store flag; 01 byte, 10 half, 11 word; load sign-extend.
REQ-010 D_req_address / D_req_wdata  input  32 / 32  data byte address and store data.
REQ-011 D_req_ready  output  1  data request accepted this cycle.
REQ-012 D_rsp_valid / D_rsp_data / D_rsp_error  output  1 / 32 / 1  response pulse, load data (0 for stores), misalignment flag.
REQ-013 MEM_en / MEM_write / MEM_length / MEM_signed  output  1 / 1 / 2 / 1  registered single-port memory command.
REQ-014 MEM_address / MEM_wdata  output  32 / 32  registered memory address and store data.
REQ-015 MEM_read_data  input  32  memory read data, valid the cycle after MEM_en=1.

Function
REQ-016 FSM states IDLE, ISSUE, CAPTURE; IDLE->ISSUE on accept; ISSUE->CAPTURE; CAPTURE->IDLE.
REQ-017 Ready outputs assert only in IDLE, at most one per cycle, combinationally from valids and the starvation counter.
REQ-018 Arbitration: data wins when both valid, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-019 starve_cnt (4 bits): +1 on data grant with IF_req_valid high; 0 on fetch grant or data grant with IF_req_valid low; saturates at STARVE_LIMIT.
REQ-020 On accept, latch requester id and command; MEM_en=1 only during ISSUE; fetch drives MEM_write=0, MEM_length=11, MEM_signed=0.
REQ-021 MEM_read_data sampled at end of CAPTURE-entry cycle (cycle after ISSUE); rsp_valid of the granted requester is a registered pulse in the following cycle.
REQ-022 Latency: accept in cycle N -> MEM_en in N+1 -> rsp_valid in N+3; new accept allowed in N+3 (rsp and ready may coincide).
REQ-023 Store: D_rsp_valid pulses at N+3 with D_rsp_data=0, D_rsp_error=0.
REQ-024 Misaligned data request (half with addr[0]=1, word with addr[1:0]!=0, length 00): accepted, MEM_en stays 0, D_rsp_valid and D_rsp_error=1 at N+3, D_rsp_data=0.
REQ-025 Misaligned fetch (addr[1:0]!=0): address forced word-aligned by clearing bits [1:0]; no error.
REQ-026 rsp_data outputs hold last value between pulses; D_rsp_error is 0 except when D_rsp_valid=1 for a misaligned request.
REQ-027 Requesters hold valid and fields stable until ready; arbiter never drops an accepted request.

Reset
REQ-028 SYS_reset=0 at a rising edge: state IDLE, starve_cnt=0, all outputs 0 (ready, rsp_valid, rsp_data, rsp_error, MEM_*) from the next cycle.
REQ-029 Reset during ISSUE or CAPTURE aborts the transaction: no rsp_valid is ever produced for it.
REQ-030 Ready outputs are 0 while SYS_reset=0.

Verification
REQ-031 Fetch only: IF addr 0x10, MEM_read_data=0x00500613 -> MEM_en cycle N+1 addr 0x10, IF_rsp_valid at N+3 with 0x00500613.
REQ-032 Contention: both valid continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; starve_cnt back to 0 after each IF grant.
REQ-033 Store byte: D addr 0x103, wdata 0xAB, length 01 -> MEM_write=1, MEM_length=01, MEM_address=0x103; D_rsp_valid N+3, data 0, error 0.
REQ-034 Misaligned lw at 0x102 -> MEM_en never 1; D_rsp_valid=1, D_rsp_error=1 at N+3.
REQ-035 Reset asserted in ISSUE cycle of a load -> no D_rsp_valid; after release, first request is accepted from IDLE with starve_cnt=0.
REQ-036 Back-to-back: new request valid at N+3 -> accepted same cycle as previous rsp_valid, MEM_en at N+4.
